// File: rtl/bch_decode_arbiter_if.sv
// Requester-side bundle of bch_decode_arbiter: requests, serial bits,
// grants and the steered decoded-bit stream.
interface bch_decode_arbiter_if #(
  parameter int REQ = 2,
  parameter int IW  = (REQ > 1) ? $clog2(REQ) : 1
);
  logic [REQ-1:0] req;
  logic [REQ-1:0] din;
  logic [REQ-1:0] gnt;
  logic           dout;
  logic           dout_valid;
  logic [IW-1:0]  dout_id;
  logic           dout_last;

  modport master (
    output req, din,
    input  gnt, dout, dout_valid, dout_id, dout_last
  );

  modport slave (
    input  req, din,
    output gnt, dout, dout_valid, dout_id, dout_last
  );
endinterface

// File: rtl/bch_decode_arbiter.sv
// Time-shares one serial BCH decoder between REQ requesters, one slot
// per codeword. BCH_ARB_FIXED_PRIO_EN selects fixed priority over RR.
module bch_decode_arbiter #(
  parameter int N         = 15,
  parameter int K         = 5,
  parameter int REQ       = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  bch_decode_arbiter_if.slave arb,
  output logic dec_reset,
  output logic dec_din,
  input  logic dec_vdout,
  input  logic dec_dout,
  output logic tag_ovf,
  output logic tag_unf
);
  localparam int IW = (REQ > 1) ? $clog2(REQ) : 1;
  localparam int CW = $clog2(N);
  localparam int OW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int NW = $clog2(TAG_DEPTH + 1);

  typedef enum logic {IDLE_SLOT, FEED_SLOT} state_t;

  typedef struct packed {
    logic          idle;
    logic [IW-1:0] id;
  } tag_t;

  state_t         state_q, state_d, cur_state;
  logic [IW-1:0]  id_q, id_d, cur_id;
  logic [CW-1:0]  cnt;
  logic           first;
  logic           last_bit;
  logic           any_req;
  logic [IW-1:0]  win, lo_win;

  assign any_req  = |arb.req;
  assign last_bit = (cnt == CW'(N - 1));

`ifdef BCH_ARB_FIXED_PRIO_EN
  always_comb begin
    lo_win = '0;
    for (int i = REQ - 1; i >= 0; i--)
      if (arb.req[i]) lo_win = IW'(i);
  end

  assign win = lo_win;
`else
  logic [IW-1:0] ptr;
  logic [IW-1:0] hi_win;
  logic          hi_hit;

  // lowest requester at or above ptr, else wrap to lowest overall
  always_comb begin
    lo_win = '0;
    hi_win = '0;
    hi_hit = 1'b0;
    for (int i = REQ - 1; i >= 0; i--) begin
      if (arb.req[i]) begin
        lo_win = IW'(i);
        if (i >= int'(ptr)) begin
          hi_win = IW'(i);
          hi_hit = 1'b1;
        end
      end
    end
  end

  assign win = hi_hit ? hi_win : lo_win;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr <= '0;
    else if ((first || last_bit) && any_req)
      ptr <= (win == IW'(REQ - 1)) ? '0 : win + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_reset <= 1'b1;
      first     <= 1'b0;
      cnt       <= '0;
      state_q   <= IDLE_SLOT;
      id_q      <= '0;
    end else begin
      dec_reset <= 1'b0;
      first     <= dec_reset;
      cnt       <= (dec_reset || last_bit) ? '0 : cnt + 1'b1;
      state_q   <= state_d;
      id_q      <= id_d;
    end
  end

  // slot 0 is decided combinationally so its first bit is not lost
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    if (first || last_bit) begin
      state_d = any_req ? FEED_SLOT : IDLE_SLOT;
      id_d    = win;
    end
  end

  assign cur_state = first ? (any_req ? FEED_SLOT : IDLE_SLOT)
                           : state_q;
  assign cur_id    = first ? win : id_q;

  always_comb begin
    arb.gnt = '0;
    dec_din = 1'b0;
    unique case (cur_state)
      FEED_SLOT: begin
        arb.gnt[cur_id] = 1'b1;
        dec_din         = arb.din[cur_id];
      end
      IDLE_SLOT: ;
    endcase
  end

  tag_t          mem [TAG_DEPTH];
  tag_t          head, tag_in;
  logic [PW-1:0] wp, rp;
  logic [NW-1:0] count;
  logic [OW-1:0] ocnt;
  logic          push, pop, wr_en, empty, full;
  logic          out_end, vld;

  assign empty   = (count == '0);
  assign full    = (count == NW'(TAG_DEPTH));
  assign head    = mem[rp];
  assign out_end = (ocnt == OW'(K - 1));
  assign push    = ~dec_reset & (cnt == '0);
  assign pop     = dec_vdout & out_end & ~empty;
  assign wr_en   = push & (~full | pop);
  assign vld     = dec_vdout & ~empty & ~head.idle;
  assign tag_in  = '{idle: (cur_state == IDLE_SLOT), id: cur_id};

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= tag_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp             <= '0;
      rp             <= '0;
      count          <= '0;
      ocnt           <= '0;
      tag_ovf        <= 1'b0;
      tag_unf        <= 1'b0;
      arb.dout       <= 1'b0;
      arb.dout_valid <= 1'b0;
      arb.dout_id    <= '0;
      arb.dout_last  <= 1'b0;
    end else begin
      if (wr_en) wp <= nxt(wp);
      if (pop)   rp <= nxt(rp);
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (dec_vdout) ocnt <= out_end ? '0 : ocnt + 1'b1;
      if (push && full && !pop) tag_ovf <= 1'b1;
      if (dec_vdout && empty)   tag_unf <= 1'b1;
      arb.dout       <= dec_vdout & ~empty & dec_dout;
      arb.dout_valid <= vld;
      arb.dout_id    <= empty ? '0 : head.id;
      arb.dout_last  <= vld & out_end;
    end
  end
endmodule

// File: doc/bch_decode_arbiter.md
Name: bch_decode_arbiter

Overview:
- Shares one serial bch_decode instance between REQ requesters, one codeword slot at a time.
- Chooses a requester at each N-bit codeword boundary and streams that requester's bits into the decoder.
- Pushes an ID tag per slot into a tag FIFO and steers the decoder's K-bit output burst back to the owning requester.
- The decoder has no input-valid, so empty slots are filled with an all-zero codeword, which is always valid. The decoded output of an empty slot is dropped.

Parameters:
- N, 15, codeword length; must match the decoder.
- K, 5, data bits per codeword; must match the decoder.
- REQ, 2, number of requesters, 2..8.
- TAG_DEPTH, 4, tag FIFO entries, power of 2; must cover codewords in flight inside the decoder.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req  in  REQ  requester i has a codeword ready; level, held until granted
- din  in  REQ  serial codeword bit from each requester, MSB first
- gnt  out  REQ  one-hot; high for exactly the N cycles of the granted slot; din[i] is sampled on those cycles
- dec_reset  out  1  active-high synchronous reset to the decoder
- dec_din  out  1  bit to decoder din
- dec_vdout  in  1  decoder vdout
- dec_dout  in  1  decoder dout
- dout  out  1  corrected data bit
- dout_valid  out  1  dout is valid
- dout_id  out  log2(REQ), minimum 1  owner of the current dout
- dout_last  out  1  high with the K-th bit of a burst
- tag_ovf  out  1  sticky: tag push attempted while the FIFO is full
- tag_unf  out  1  sticky: dec_vdout seen with the FIFO empty

Behaviour:
- Reset: all outputs are 0 while reset_n is low, except dec_reset, which is 1. The FIFO is emptied, the bit counter is set to 0 and the RR pointer is set to 0.
- dec_reset: stays 1 for the first clk edge after reset_n deasserts, then 0. The decoder and this block therefore start slot 0 on the same cycle.
- Bit counter: cnt runs 0..N-1 continuously, one bit per cycle, never stalls. It wraps at N-1 to 0.
- Arbitration: happens in the cycle where cnt==N-1, and in the first cycle after dec_reset falls.
  - Round robin: start the search at the RR pointer and take the first i with req[i]=1.
  - The RR pointer moves to winner+1 mod REQ.
  - Arbitration in the cycle after dec_reset falls is combinational. A req[i] that is high in that cycle is granted slot 0 and gnt[i] is high from that cycle, so the first N-bit slot is not lost.
- States:
  - IDLE_SLOT: no requester is pending. dec_din=0, gnt=0, tag=IDLE.
  - FEED_SLOT: dec_din=din[winner] and gnt[winner]=1 for cnt 0..N-1.
  - The state is re-decided at every boundary. Back-to-back slots to the same or different requesters are allowed with no gap.
- Requester contract: req may drop during a slot. The slot still completes, and din is sampled anyway.
- Tag push: at cnt==0 of every slot, including IDLE slots. The tag is {idle_flag, id}.
  - If the FIFO is full, the tag is discarded and tag_ovf is set.
- Output path, registered, 1-cycle latency from dec_vdout/dec_dout:
  - dout=dec_dout and dout_id=head.id.
  - dout_valid=dec_vdout & ~head.idle & fifo_nonempty.
- Output bit counter: counts dec_vdout cycles 0..K-1.
  - At K-1, dout_last=dout_valid and the head tag is popped.
  - An IDLE head is popped the same way, with dout_valid held 0.
- FIFO empty: if dec_vdout arrives with the FIFO empty, set tag_unf. Outputs stay 0 and the output bit counter still advances.
- Simultaneous push and pop on a full FIFO: allowed; no overflow is flagged.
- Simultaneous push and pop on an empty FIFO: the pop sees empty, so tag_unf is set.
- tag_ovf and tag_unf clear only on reset.
- Reset mid-slot: the current slot is abandoned with no partial output. The decoder is re-reset through dec_reset.

Optional Feature:
- Macro: BCH_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The RR pointer is removed.
- Undefined: round robin as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Idle: reset, then req=0 for 10 slots -> dec_din constant 0; dout_valid never 1; tag_ovf=0; tag_unf=0.
- Single codeword: req[1]=1 in the cycle after dec_reset falls, with a valid N=15 codeword for data 5'b10110 -> gnt=2'b10 for exactly 15 cycles; later 5 dout_valid bits 1,0,1,1,0 with dout_id=1 and dout_last on the 5th.
- Error correction: the same codeword with 3 bits flipped -> output still 10110; with 4 flipped, no check on data, but the bursts stay aligned.
- Round robin: req=2'b11 held, alternating codewords A (data 5'h0A, req 0) and B (data 5'h15, req 1) -> grants 0,1,0,1; output bursts 0A/id0, 15/id1, 0A/id0, 15/id1 in order, no gaps.
- Fixed priority with BCH_ARB_FIXED_PRIO_EN: req=2'b11 -> req 0 wins every slot; gnt[1] stays 0.
- Boundaries:
  - TAG_DEPTH=1 with decoder latency >1 slot -> tag_ovf sets and stays set.
  - reset_n pulsed low mid-slot -> all outputs 0; dec_reset=1; normal restart on release.
